// File: rtl/gabor_win_pkg.sv
// Shared constants for the 5x5 Gabor window front end: window geometry,
// tap numbering and the symmetric-sum group membership (GABOR_WIN_SYMSUM_EN).
package gabor_win_pkg;

  localparam int WIN_N             = 5;
  localparam int WIN_TAPS          = 25;
  localparam int GSUM_GROUPS       = 5;
  localparam int GSUM_MAX_MEMBERS  = 8;

  // Tap numbers (1..25) per group; 0 pads the shorter groups.
  localparam int GSUM_TAPS [GSUM_GROUPS][GSUM_MAX_MEMBERS] = '{
    '{ 1, 25,  0,  0,  0,  0,  0,  0},
    '{ 2, 24,  6, 20,  0,  0,  0,  0},
    '{ 3, 23,  7, 19, 11, 15,  0,  0},
    '{ 4,  5, 21, 22,  8, 16, 10, 18},
    '{ 9, 12, 13, 14, 17,  0,  0,  0}
  };

  function automatic int tap(input int row, input int col);
    return WIN_N * row + col + 1;
  endfunction

endpackage

// File: rtl/gabor_window_gen_5x5_if.sv
// Stream interface of the 5x5 window generator: pixel in, window out.
// out_gsum exists only when GABOR_WIN_SYMSUM_EN is defined.
interface gabor_window_gen_5x5_if #(
  parameter int PIXEL_W = 8
);
  import gabor_win_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [PIXEL_W-1:0]            in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [WIN_TAPS*PIXEL_W-1:0]   out_win;
  logic                          out_last;
`ifdef GABOR_WIN_SYMSUM_EN
  logic [GSUM_GROUPS*(PIXEL_W+3)-1:0] out_gsum;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_win, out_last, out_gsum
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_win, out_last, out_gsum
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_win, out_last
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_win, out_last
  );
`endif

endinterface

// File: rtl/gabor_line_buffer.sv
// One-line pixel delay: read-before-write RAM addressed by the column counter,
// so o_data is the pixel written at this column one accepted line earlier.
module gabor_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  assign o_data = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[i_addr] <= i_data;
    end
  end

endmodule

// File: rtl/gabor_window_gen_5x5.sv
// Raster-to-5x5-window generator with a one-deep registered output stage.
// Optional symmetric group sums are enabled by defining GABOR_WIN_SYMSUM_EN.
module gabor_window_gen_5x5
  import gabor_win_pkg::*;
#(
  parameter int PIXEL_W = 8,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480
) (
  input  logic                   clk,
  input  logic                   rst,
  gabor_window_gen_5x5_if.slave  bus
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]            r_col;
  logic [ROW_W-1:0]            r_row;
  logic                        r_outValid;
  logic                        r_outLast;
  logic [WIN_TAPS*PIXEL_W-1:0] r_outWin;

  logic                        w_inReady;
  logic                        w_accept;
  logic                        w_winHit;
  logic                        w_frameEnd;
  logic [PIXEL_W-1:0]          w_lb0, w_lb1, w_lb2, w_lb3;
  logic [PIXEL_W-1:0]          w_newCol [WIN_N];
  logic [PIXEL_W-1:0]          r_hist   [WIN_N][WIN_N-1];
  logic [PIXEL_W-1:0]          w_next   [WIN_N][WIN_N];
  logic [WIN_TAPS*PIXEL_W-1:0] w_nextFlat;

  assign w_inReady  = !r_outValid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_inReady;
  assign w_winHit   = (r_row >= ROW_W'(WIN_N - 1)) && (r_col >= COL_W'(WIN_N - 1));
  assign w_frameEnd = (r_row == ROW_MAX) && (r_col == COL_MAX);

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.out_last  = r_outLast;
  assign bus.out_win   = r_outWin;

  // Chained delay lines: buffer n lags the input by n+1 lines.
  gabor_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIXEL_W), .AW(COL_W)) u_lb0 (
    .clk(clk), .i_en(w_accept), .i_addr(r_col), .i_data(bus.in_data), .o_data(w_lb0)
  );
  gabor_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIXEL_W), .AW(COL_W)) u_lb1 (
    .clk(clk), .i_en(w_accept), .i_addr(r_col), .i_data(w_lb0), .o_data(w_lb1)
  );
  gabor_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIXEL_W), .AW(COL_W)) u_lb2 (
    .clk(clk), .i_en(w_accept), .i_addr(r_col), .i_data(w_lb1), .o_data(w_lb2)
  );
  gabor_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIXEL_W), .AW(COL_W)) u_lb3 (
    .clk(clk), .i_en(w_accept), .i_addr(r_col), .i_data(w_lb2), .o_data(w_lb3)
  );

  assign w_newCol[0] = w_lb3;
  assign w_newCol[1] = w_lb2;
  assign w_newCol[2] = w_lb1;
  assign w_newCol[3] = w_lb0;
  assign w_newCol[4] = bus.in_data;

  // Window ending at the pixel being accepted: four stored columns plus the new one.
  always_comb begin
    for (int r = 0; r < WIN_N; r++) begin
      for (int c = 0; c < WIN_N - 1; c++) begin
        w_next[r][c] = r_hist[r][c];
      end
      w_next[r][WIN_N-1] = w_newCol[r];
    end
  end

  always_comb begin
    w_nextFlat = '0;
    for (int r = 0; r < WIN_N; r++) begin
      for (int c = 0; c < WIN_N; c++) begin
        w_nextFlat[(tap(r, c) - 1) * PIXEL_W +: PIXEL_W] = w_next[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int r = 0; r < WIN_N; r++) begin
        for (int c = 0; c < WIN_N - 1; c++) begin
          r_hist[r][c] <= w_next[r][c+1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

`ifdef GABOR_WIN_SYMSUM_EN
  localparam int GSUM_W = PIXEL_W + 3;

  logic [GSUM_GROUPS*GSUM_W-1:0] w_gsum;
  logic [GSUM_GROUPS*GSUM_W-1:0] r_gsum;

  assign bus.out_gsum = r_gsum;

  always_comb begin
    w_gsum = '0;
    for (int g = 0; g < GSUM_GROUPS; g++) begin
      for (int m = 0; m < GSUM_MAX_MEMBERS; m++) begin
        if (GSUM_TAPS[g][m] != 0) begin
          w_gsum[g*GSUM_W +: GSUM_W] = w_gsum[g*GSUM_W +: GSUM_W] +
            GSUM_W'(w_nextFlat[((GSUM_TAPS[g][m] == 0) ? 0 : GSUM_TAPS[g][m] - 1) * PIXEL_W +: PIXEL_W]);
        end
      end
    end
  end
`endif

  // Output register: a new window may replace the current one in the cycle it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
      r_outWin   <= '0;
`ifdef GABOR_WIN_SYMSUM_EN
      r_gsum     <= '0;
`endif
    end else if (w_accept && w_winHit) begin
      r_outValid <= 1'b1;
      r_outLast  <= w_frameEnd;
      r_outWin   <= w_nextFlat;
`ifdef GABOR_WIN_SYMSUM_EN
      r_gsum     <= w_gsum;
`endif
    end else if (bus.out_ready) begin
      r_outValid <= 1'b0;
    end
  end

endmodule
